// File: rtl/decode_hazard_scoreboard_pkg.sv
// Shared constants and types for the decode hazard scoreboard.
// Optional build macro: SCOREBOARD_PERF_EN (stall performance counters).
package decode_hazard_scoreboard_pkg;

  localparam int REGISTER_WIDTH = 5;
  localparam int SB_CNT_WIDTH   = 2;
  localparam int NUM_REGS       = 2 ** REGISTER_WIDTH;
  localparam int INFLIGHT_W     = REGISTER_WIDTH + SB_CNT_WIDTH;

  typedef logic [SB_CNT_WIDTH-1:0]   sb_cnt_t;
  typedef logic [REGISTER_WIDTH-1:0] sb_reg_idx_t;

  // One register-targeted event (issue, kill or writeback)
  typedef struct packed {
    logic        valid;
    sb_reg_idx_t regnum;
  } sb_event_t;

  // Build an event; x0 is never tracked, so events naming it are dropped
  function automatic sb_event_t sb_mk_event(input logic valid, input sb_reg_idx_t regnum);
    sb_event_t ev;
    ev.valid  = valid & (regnum != '0);
    ev.regnum = regnum;
    return ev;
  endfunction

endpackage

// File: rtl/decode_hazard_scoreboard_if.sv
// Decode/ALU/writeback-facing signal bundle of the hazard scoreboard.
// Optional build macro: SCOREBOARD_PERF_EN adds the two perf counter outputs.
interface decode_hazard_scoreboard_if;
  import decode_hazard_scoreboard_pkg::*;

  logic                      dec_valid_i;
  logic                      dec_uses_rs1_i;
  logic                      dec_uses_rs2_i;
  logic [REGISTER_WIDTH-1:0] dec_rs1_i;
  logic [REGISTER_WIDTH-1:0] dec_rs2_i;
  logic                      dec_wr_en_i;
  logic [REGISTER_WIDTH-1:0] dec_rd_i;
  logic                      mem_stall_i;
  logic                      kill_i;
  logic [REGISTER_WIDTH-1:0] kill_rd_i;
  logic                      wb_reg_wr_en_i;
  logic [REGISTER_WIDTH-1:0] wb_wr_reg_i;
  logic                      stall_o;
  logic                      issue_o;
  logic [INFLIGHT_W-1:0]     inflight_o;
  logic                      err_o;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0]               stall_cycles_o;
  logic [31:0]               ovf_stalls_o;
`endif

  // Pipeline side: drives decode/kill/writeback, observes the scoreboard
  modport master (
    output dec_valid_i, dec_uses_rs1_i, dec_uses_rs2_i, dec_rs1_i, dec_rs2_i,
    output dec_wr_en_i, dec_rd_i, mem_stall_i, kill_i, kill_rd_i,
    output wb_reg_wr_en_i, wb_wr_reg_i,
`ifdef SCOREBOARD_PERF_EN
    input  stall_cycles_o, ovf_stalls_o,
`endif
    input  stall_o, issue_o, inflight_o, err_o
  );

  // Scoreboard side
  modport slave (
    input  dec_valid_i, dec_uses_rs1_i, dec_uses_rs2_i, dec_rs1_i, dec_rs2_i,
    input  dec_wr_en_i, dec_rd_i, mem_stall_i, kill_i, kill_rd_i,
    input  wb_reg_wr_en_i, wb_wr_reg_i,
`ifdef SCOREBOARD_PERF_EN
    output stall_cycles_o, ovf_stalls_o,
`endif
    output stall_o, issue_o, inflight_o, err_o
  );

endinterface

// File: rtl/decode_hazard_scoreboard_sb_reg_counter.sv
// Outstanding-write counter for one architectural register: +1 on issue,
// -1 each for writeback and kill, clamped to [0, 2**CNT_WIDTH-1].
module sb_reg_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec_wb,
  input  logic                 dec_kill,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] cnt_next,
  output logic                 underflow
);

  localparam logic [CNT_WIDTH:0] CNT_MAX = (CNT_WIDTH+1)'((2 ** CNT_WIDTH) - 1);

  logic [CNT_WIDTH:0] up;
  logic [CNT_WIDTH:0] down;
  logic [CNT_WIDTH:0] diff;

  // Net update of all same-cycle events, clamped at both ends
  always_comb begin
    up        = {1'b0, cnt} + {{CNT_WIDTH{1'b0}}, inc};
    down      = {{CNT_WIDTH{1'b0}}, dec_wb} + {{CNT_WIDTH{1'b0}}, dec_kill};
    diff      = up - down;
    underflow = 1'b0;
    cnt_next  = diff[CNT_WIDTH-1:0];
    if (down > up) begin
      underflow = 1'b1;
      cnt_next  = '0;
    end else if (diff > CNT_MAX) begin
      cnt_next  = CNT_MAX[CNT_WIDTH-1:0];
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

endmodule

// File: rtl/decode_hazard_scoreboard.sv
// Per-register write scoreboard beside decode: raises a combinational stall
// on RAW or counter-overflow hazards and tracks in-flight writes until
// writeback or squash. Optional build macro: SCOREBOARD_PERF_EN.
module decode_hazard_scoreboard #(
  parameter int REGISTER_WIDTH = decode_hazard_scoreboard_pkg::REGISTER_WIDTH,
  parameter int CNT_WIDTH      = decode_hazard_scoreboard_pkg::SB_CNT_WIDTH
) (
  input logic                         clk_i,
  input logic                         rst_i,
  decode_hazard_scoreboard_if.slave   bus
);
  import decode_hazard_scoreboard_pkg::*;

  localparam int NREGS = 2 ** REGISTER_WIDTH;
  localparam int INF_W = REGISTER_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt      [NREGS];
  logic [CNT_WIDTH-1:0] cnt_next [NREGS];
  logic [NREGS-1:0]     underflow;

  logic      haz_rs1;
  logic      haz_rs2;
  logic      haz_ovf;
  logic      stall;
  logic      issue;
  sb_event_t iss_ev;
  sb_event_t wb_ev;
  sb_event_t kill_ev;
  logic [INF_W-1:0] inflight_next;

  // x0 is hard-wired to an empty reservation
  assign cnt[0]       = '0;
  assign cnt_next[0]  = '0;
  assign underflow[0] = 1'b0;

  // Hazard detection; a retiring last writer is forwarded, so it does not stall
  always_comb begin
    haz_rs1 = bus.dec_uses_rs1_i & (cnt[bus.dec_rs1_i] != '0) &
              !(bus.wb_reg_wr_en_i & (bus.wb_wr_reg_i == bus.dec_rs1_i) &
                (cnt[bus.dec_rs1_i] == CNT_WIDTH'(1)));
    haz_rs2 = bus.dec_uses_rs2_i & (cnt[bus.dec_rs2_i] != '0) &
              !(bus.wb_reg_wr_en_i & (bus.wb_wr_reg_i == bus.dec_rs2_i) &
                (cnt[bus.dec_rs2_i] == CNT_WIDTH'(1)));
    haz_ovf = bus.dec_wr_en_i & (bus.dec_rd_i != '0) & (cnt[bus.dec_rd_i] == CNT_MAX);
    stall   = bus.dec_valid_i & (haz_rs1 | haz_rs2 | haz_ovf);
    issue   = bus.dec_valid_i & !stall & !bus.mem_stall_i;
    iss_ev  = sb_mk_event(issue & bus.dec_wr_en_i, bus.dec_rd_i);
    wb_ev   = sb_mk_event(bus.wb_reg_wr_en_i, bus.wb_wr_reg_i);
    kill_ev = sb_mk_event(bus.kill_i, bus.kill_rd_i);
  end

  assign bus.stall_o = stall;
  assign bus.issue_o = issue;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    sb_reg_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk       (clk_i),
      .rst       (rst_i),
      .inc       (iss_ev.valid  && (iss_ev.regnum  == REGISTER_WIDTH'(r))),
      .dec_wb    (wb_ev.valid   && (wb_ev.regnum   == REGISTER_WIDTH'(r))),
      .dec_kill  (kill_ev.valid && (kill_ev.regnum == REGISTER_WIDTH'(r))),
      .cnt       (cnt[r]),
      .cnt_next  (cnt_next[r]),
      .underflow (underflow[r])
    );
  end

  // Total of the post-update counters, so it always agrees with the per-register state
  always_comb begin
    inflight_next = '0;
    for (int r = 1; r < NREGS; r++) begin
      inflight_next = inflight_next + INF_W'(cnt_next[r]);
    end
  end

  // Registered in-flight total
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bus.inflight_o <= '0;
    else       bus.inflight_o <= inflight_next;
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           bus.err_o <= 1'b0;
    else if (|underflow) bus.err_o <= 1'b1;
  end

`ifdef SCOREBOARD_PERF_EN
  // Cycles decode was held by the scoreboard and not by a memory freeze
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          bus.stall_cycles_o <= '0;
    else if (stall && !bus.mem_stall_i) bus.stall_cycles_o <= bus.stall_cycles_o + 32'd1;
  end

  // Cycles where only the counter-overflow hazard held decode
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      bus.ovf_stalls_o <= '0;
    else if (bus.dec_valid_i && haz_ovf && !haz_rs1 && !haz_rs2)
      bus.ovf_stalls_o <= bus.ovf_stalls_o + 32'd1;
  end
`endif

endmodule

// File: doc/decode_hazard_scoreboard.md
Name: decode_hazard_scoreboard

Overview:
- Per-register scoreboard that sequences the decode stage.
- Tracks every architectural register with an in-flight write between decode issue and writeback.
- Raises a combinational stall to decode on read-after-write (RAW) or counter-overflow hazards.
- Sits beside the decode stage. Fed by decode (issue), the ALU stage (squash/kill) and writeback (retire).

Parameters:
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH (5): register index width.
- NUM_REGS, 2**REGISTER_WIDTH: number of tracked architectural registers.
- CNT_WIDTH, params_pkg::SB_CNT_WIDTH (2): per-register outstanding-write counter width. Saturates at 2**CNT_WIDTH-1.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset, asynchronous, active-high.
- dec_valid_i  in  1  decode holds a valid instruction.
- dec_uses_rs1_i  in  1  instruction reads rs1.
- dec_uses_rs2_i  in  1  instruction reads rs2.
- dec_rs1_i  in  REGISTER_WIDTH  source register 1.
- dec_rs2_i  in  REGISTER_WIDTH  source register 2.
- dec_wr_en_i  in  1  instruction writes rd.
- dec_rd_i  in  REGISTER_WIDTH  destination register.
- mem_stall_i  in  1  global pipeline freeze.
- kill_i  in  1  instruction in ALU stage squashed (taken branch/jump).
- kill_rd_i  in  REGISTER_WIDTH  rd of the squashed instruction.
- wb_reg_wr_en_i  in  1  writeback retiring a register write.
- wb_wr_reg_i  in  REGISTER_WIDTH  register written at writeback.
- stall_o  out  1  decode must hold its instruction (combinational).
- issue_o  out  1  instruction leaves decode this cycle (combinational).
- inflight_o  out  REGISTER_WIDTH+CNT_WIDTH  total outstanding tracked writes (registered).
- err_o  out  1  sticky underflow error (registered).

Behaviour:
- Reset (async, rst_i=1):
  - All per-register counters = 0.
  - inflight_o = 0.
  - err_o = 0.
  - stall_o/issue_o then follow their equations with empty state.
- Register 0 is never tracked:
  - Its counter is constantly 0.
  - Issue, kill or writeback to x0 has no effect.
  - x0 never causes a hazard.
- Source hazard, per rsN (N = 1, 2):
  - haz_rsN = dec_uses_rsN_i & cnt[rsN] != 0 & !(wb_reg_wr_en_i & wb_wr_reg_i == rsN & cnt[rsN] == 1).
  - The exception mirrors the decode writeback bypass: the last outstanding writer retiring this cycle is forwarded, so there is no stall.
- Overflow hazard:
  - haz_ovf = dec_wr_en_i & dec_rd_i != 0 & cnt[dec_rd_i] == max.
- stall_o = dec_valid_i & (haz_rs1 | haz_rs2 | haz_ovf).
- issue_o = dec_valid_i & !stall_o & !mem_stall_i.
- Counter update per register r, all events applied in the same cycle:
  - inc = issue_o & dec_wr_en_i & dec_rd_i == r.
  - dec_wb = wb_reg_wr_en_i & wb_wr_reg_i == r.
  - dec_kill = kill_i & kill_rd_i == r.
  - next = cnt + inc - dec_wb - dec_kill.
  - Writeback and kill are never gated by mem_stall_i.
- Underflow:
  - If the decrements exceed cnt + inc, the counter clamps at 0 and err_o sets.
  - err_o clears only on reset.
- inflight_o tracks the sum of all counters, updated with the same net delta and clamped at 0.
- Latency: a tracked write is visible to stall_o the cycle after issue.
- Simultaneous events on the same rd:
  - Issue + writeback: counter unchanged.
  - Issue + writeback + kill: counter −1.
- Reset mid-operation discards all reservations immediately.
- kill_i without a matching prior reservation (kill_rd_i == 0) is ignored.

Optional Feature:
- Macro: SCOREBOARD_PERF_EN.
- When defined, adds two ports:
  - stall_cycles_o, 32-bit, counts cycles with stall_o=1 & !mem_stall_i.
  - ovf_stalls_o, 32-bit, counts cycles where haz_ovf alone caused the stall.
- Both counters: reset to 0, wrap at 2**32.
- When undefined, the ports and logic are absent. Core behaviour is identical.

Decomposition:
- params_pkg gains:
  - SB_CNT_WIDTH = 2.
  - typedef sb_cnt_t (logic [SB_CNT_WIDTH-1:0]).
  - typedef sb_event_t, a struct {valid, reg} shared by the issue, kill and writeback inputs.
- One sub-module, sb_reg_counter: a single saturating up/down counter with inc, dec_wb and dec_kill inputs, an underflow flag and asynchronous reset. It is instantiated NUM_REGS-1 times in a generate loop.

Test Plan:
- Reset, then decode rs1=3 with no writes in flight → stall_o=0, issue_o=1, inflight_o=0.
- Issue writing x5, next cycle decode reading x5 → stall_o=1. Writeback x5 (cnt=1) that cycle → stall_o=0, instruction issues, cnt[5]=0.
- Three issues writing x7 without writeback → cnt[7]=3. Fourth issue writing x7 → stall_o=1 (haz_ovf); one writeback x7 releases it.
- Issue x9 and writeback x9 in the same cycle with cnt[9]=1 → cnt[9] stays 1, inflight_o unchanged.
- Issue x4, kill_i with kill_rd_i=4 next cycle → cnt[4]=0, later read of x4 → no stall. Writeback x4 with cnt=0 → err_o=1 and stays set.
- Assert rst_i asynchronously mid-run with cnt[2]=2 → counters, inflight_o and err_o are 0 before the next clock edge. Decode or writeback to x0 → no stall, no count change.
